// File: rtl/autosym_scan_ctrl.sv
// Sweeps an external single-output function over all 2^N inputs, checking
// f(x) == f(x ^ alpha) for every x and counting the on-set along the way.
module autosym_scan_ctrl #(
    parameter int N      = 10,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] alpha,
    input  logic         stop_on_fail,
    output logic [N-1:0] fn_x,
    input  logic         fn_y,
    output logic         busy,
    output logic         done,
    output logic         is_sym,
    output logic [N-1:0] mismatch_x,
    output logic [N:0]   onset_cnt,
    output logic         full_sweep
);

    typedef enum logic [1:0] {
        IDLE,
        PH_A,
        PH_B,
        FIN
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

    state_t       state;
    logic [N-1:0] x;
    logic [N-1:0] alpha_q;
    logic         sof_q;
    logic [3:0]   settle;
    logic         ya;

    // Each phase holds fn_x for SETTLE+1 cycles; fn_y is sampled on the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            alpha_q    <= '0;
            sof_q      <= 1'b0;
            settle     <= '0;
            ya         <= 1'b0;
            fn_x       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            is_sym     <= 1'b0;
            mismatch_x <= '0;
            onset_cnt  <= '0;
            full_sweep <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alpha_q    <= alpha;
                        sof_q      <= stop_on_fail;
                        x          <= '0;
                        settle     <= '0;
                        onset_cnt  <= '0;
                        mismatch_x <= '0;
                        is_sym     <= 1'b1;
                        full_sweep <= 1'b0;
                        busy       <= 1'b1;
                        fn_x       <= '0;
                        state      <= PH_A;
                    end
                end
                PH_A: begin
                    if (settle == SETTLE_LAST) begin
                        settle <= '0;
                        ya     <= fn_y;
                        if (fn_y) begin
                            onset_cnt <= onset_cnt + (N+1)'(1);
                        end
                        fn_x  <= x ^ alpha_q;
                        state <= PH_B;
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                PH_B: begin
                    if (settle == SETTLE_LAST) begin
                        settle <= '0;
                        // Only the first mismatch is recorded; is_sym doubles as the "none yet" flag.
                        if ((fn_y != ya) && is_sym) begin
                            mismatch_x <= x;
                            is_sym     <= 1'b0;
                        end
                        if ((fn_y != ya) && is_sym && sof_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            fn_x  <= '0;
                            state <= FIN;
                        end else if (&x) begin
                            full_sweep <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            fn_x       <= '0;
                            state      <= FIN;
                        end else begin
                            x     <= x + N'(1);
                            fn_x  <= x + N'(1);
                            state <= PH_A;
                        end
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/autosym_scan_ctrl.md
Name: autosym_scan_ctrl

Overview:
Sequencer that drives an external combinational single-output Boolean function (N inputs, one output) through its whole input space. For a candidate translation vector alpha, it checks f(x) == f(x ^ alpha) for every x, i.e. whether alpha lies in the function's autosymmetry space. It also counts the on-set size. It sits between a test/host controller and one optimized benchmark netlist instance, whose inputs it owns.

Parameters:
N, 10, number of function inputs (x0..x(N-1)); supported range 1..16
SETTLE, 1, cycles the driven vector is held before fn_y is sampled; supported range 1..15

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
alpha  input  N  translation vector under test; latched on accepted start
stop_on_fail  input  1  latched on start; 1 = abort at first mismatch
fn_x  output  N  registered vector driven to the function inputs (bit i -> xi)
fn_y  input  1  function output y0, combinational from fn_x
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a scan ends
is_sym  output  1  valid with done and held until next start; 1 = no mismatch found
mismatch_x  output  N  first x with f(x) != f(x^alpha); 0 if none
onset_cnt  output  N+1  number of x with f(x)=1; valid only if the scan was a full sweep
full_sweep  output  1  valid with done; 1 = all 2^N vectors visited

Behaviour:
- Reset (async assert, sync release): state IDLE; fn_x=0, busy=0, done=0, is_sym=0, mismatch_x=0, onset_cnt=0, full_sweep=0; internal x counter, settle counter and captured sample cleared.
- States: IDLE, PH_A, PH_B, FIN.
- IDLE: on start=1, latch alpha and stop_on_fail; clear x counter, onset_cnt, mismatch_x; set is_sym=1 and full_sweep=0; go to PH_A. busy rises the cycle after start.
- PH_A: fn_x = x. Hold for SETTLE+1 cycles. At the last cycle's edge, capture ya = fn_y and increment onset_cnt if ya=1. Then go to PH_B.
- PH_B: fn_x = x ^ alpha. Hold for SETTLE+1 cycles. At the last edge, compare fn_y with ya.
  - On mismatch with is_sym still 1: record mismatch_x = x and clear is_sym. If stop_on_fail=1, go to FIN with full_sweep=0.
  - Otherwise, if x = 2^N-1, set full_sweep=1 and go to FIN. Else x = x+1 and go to PH_A.
- Only the first mismatch is recorded. Later mismatches in a continued sweep leave mismatch_x unchanged.
- FIN: busy=0, done=1 for exactly one cycle, fn_x=0, then IDLE. Result outputs hold until the next accepted start.
- Latency of a full sweep: busy high for 2^N * 2 * (SETTLE+1) cycles; done follows in the next cycle.
- fn_x changes only on state or phase entry, never mid-settle.
- alpha=0 is legal: full sweep, is_sym=1, onset counted normally.
- onset_cnt counts only PH_A samples. It reaches 2^N without overflow, hence width N+1.
- start during busy/FIN is ignored. Changes to alpha or stop_on_fail during a scan have no effect.
- Reset mid-scan aborts immediately to reset values; no done pulse.
- x counter wraps only via the final-vector check, never silently.

Test Plan:
- N=2, SETTLE=1, f=x0^x1, alpha=2'b11, stop_on_fail=0 -> busy exactly 16 cycles, done pulse, is_sym=1, full_sweep=1, onset_cnt=2, mismatch_x=0; fn_x sequence 0,3,1,2,2,1,3,0, each held 2 cycles.
- N=10, SETTLE=1, f=x0^x1, alpha=10'h001, stop_on_fail=1 -> is_sym=0, mismatch_x=0, full_sweep=0, done after 4 busy cycles.
- N=10, f=x3&~x0, alpha=10'h004, stop_on_fail=0 -> is_sym=1, onset_cnt=256, full_sweep=1; busy 4096 cycles at SETTLE=1.
- N=10, f=constant 0, alpha=0 -> is_sym=1, onset_cnt=0; repeat with f=constant 1 -> onset_cnt=1024, no overflow.
- Start pulsed during busy, with alpha changed mid-scan -> ignored, result reflects the original alpha; busy length unchanged.
- rst_n pulled low mid-PH_B -> all outputs 0 asynchronously, no done; a new start after release performs a clean full scan with correct results.
